// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide family: FSM state encoding and default width.
package mult_div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift {rem, quo} left by one, trial-subtract the divisor,
// keep the difference and set the quotient LSB only when it is non-negative.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH:0]   dvsr_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             unused_rem_msb;

  // The partial remainder stays below the divisor, so its top bit is always clear here.
  assign unused_rem_msb = rem_i[WIDTH];
  assign shifted        = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
  assign diff           = {1'b0, shifted} - {1'b0, dvsr_i};

  always_comb begin
    rem_o = shifted;
    quo_o = {quo_i[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH+1]) begin
      rem_o = diff[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/sequential_divider.sv
// Signed WIDTH-bit restoring divider: magnitudes are divided over WIDTH CALC cycles,
// then FIX applies the sign rules and publishes the result with a one-cycle done pulse.
module sequential_divider
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output div_state_e       state_o
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             sd_q, sd_d, sv_q, sv_d, dz_q, dz_d;
  logic [WIDTH-1:0] quot_q, quot_d, rmd_q, rmd_d;
  logic             done_q, done_d, dbz_q, dbz_d;

  logic [WIDTH:0]   ext_dvd, ext_dvs, abs_dvd, abs_dvs;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             unused_abs_msb;

  // Magnitudes at WIDTH+1 bits so the most negative operand has an exact absolute value.
  assign ext_dvd        = {dividend[WIDTH-1], dividend};
  assign ext_dvs        = {divisor[WIDTH-1], divisor};
  assign abs_dvd        = dividend[WIDTH-1] ? -ext_dvd : ext_dvd;
  assign abs_dvs        = divisor[WIDTH-1] ? -ext_dvs : ext_dvs;
  assign unused_abs_msb = abs_dvd[WIDTH];

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    sd_d    = sd_q;
    sv_d    = sv_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sd_d    = dividend[WIDTH-1];
          sv_d    = divisor[WIDTH-1];
          dz_d    = (divisor == '0);
          quo_d   = abs_dvd[WIDTH-1:0];
          dvsr_d  = abs_dvs;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = (divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        // With a zero divisor quo_q still holds |dividend|, which restores the dividend.
        if (dz_q) begin
          quot_d = '1;
          rmd_d  = sd_q ? -quo_q : quo_q;
        end else begin
          quot_d = (sd_q ^ sv_q) ? -quo_q : quo_q;
          rmd_d  = sd_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        end
        dbz_d   = dz_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      sd_q    <= 1'b0;
      sv_q    <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      sd_q    <= sd_d;
      sv_q    <= sv_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);
  assign state_o     = state_q;

endmodule

// File: doc/sequential_divider.md
SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a division, sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, WIDTH bits, a signed two's-complement numerator.
REQ-006 The block SHALL have port divisor, input, WIDTH bits, a signed two's-complement denominator.
REQ-007 The block SHALL have port quotient, output, WIDTH bits, the signed result truncated toward zero.
REQ-008 The block SHALL have port remainder, output, WIDTH bits, the signed remainder, whose sign follows the dividend.
REQ-009 The block SHALL have port busy, output, 1 bit, high while in CALC or FIX.
REQ-010 The block SHALL have port done, output, 1 bit, a single-cycle pulse when the results are valid.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit, high with done when the divisor was zero, and held until the next accepted start.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, CALC and FIX.
REQ-013 In IDLE with start=1, the block SHALL register |dividend| and |divisor| and both operand signs, clear the partial remainder, set the iteration count to 0 and move to CALC.
REQ-014 CALC SHALL perform one restoring step per cycle: shift {rem, quo} left 1, trial-subtract |divisor|, and keep the result and set the quotient LSB only if the difference is non-negative.
REQ-015 CALC SHALL last exactly WIDTH cycles and then move to FIX.
REQ-016 FIX SHALL negate the quotient if the operand signs differ and negate the remainder if the dividend is negative, load quotient and remainder, pulse done and return to IDLE.
REQ-017 Latency SHALL be WIDTH+2 rising edges from the start-sampling edge to the edge that raises done (34 for WIDTH=32).
REQ-018 quotient, remainder and div_by_zero SHALL hold their values from done until the next accepted start; they SHALL NOT change during a computation.
REQ-019 start SHALL be ignored while busy=1; an in-flight operation is never restarted.
REQ-020 start held high continuously SHALL launch back-to-back divisions, with the next accepted in the IDLE cycle following done.
REQ-021 A zero divisor SHALL skip CALC: the block goes IDLE->FIX, and the outputs are quotient = all ones, remainder = dividend, div_by_zero = 1, done on the 2nd edge.
REQ-022 The overflow case dividend = -2^(WIDTH-1), divisor = -1 SHALL yield quotient = -2^(WIDTH-1) and remainder = 0, with no flag.
REQ-023 Absolute values SHALL be formed at WIDTH+1 bits so that |-2^(WIDTH-1)| is exact.
REQ-024 The internal partial remainder SHALL be WIDTH+1 bits.

Reset
REQ-025 rst=0 SHALL immediately force IDLE and clear quotient, remainder, busy, done, div_by_zero, the iteration counter and all datapath registers, independent of clk.
REQ-026 Reset asserted mid-CALC or mid-FIX SHALL abort the operation; no done is produced for it.
REQ-027 After rst is released, the first start SHALL be accepted on the first rising edge at which it is sampled.

Structure
REQ-028 A shared package mult_div_pkg SHALL hold the FSM state enum (IDLE, CALC, FIX) and the default WIDTH constant, for reuse by the multiplier family.
REQ-029 One sub-module, div_restore_step, SHALL implement the combinational single-iteration shift/trial-subtract.
REQ-030 The counter, FSM and sign correction SHALL reside in sequential_divider.

Verification
REQ-031 Scenario: 83810205 / 6789 -> quotient 12345, remainder 0, done exactly 34 cycles after start.
REQ-032 Scenario: -100/7, 100/-7 and -100/-7 -> (-14, -2), (-14, 2) and (14, -2).
REQ-033 Scenario: -2147483648 / -1 -> quotient 0x8000_0000, remainder 0, div_by_zero=0; then 2147483647 / 1 -> 2147483647, remainder 0.
REQ-034 Scenario: 123456789 / 0 -> quotient 0xFFFF_FFFF, remainder 123456789, div_by_zero=1, done 2 cycles after start.
REQ-035 Scenario: start 1000/3; rst=0 at cycle 10 -> outputs 0 immediately, no done. Then start 1000/3 -> 333 r 1 after 34 cycles.
REQ-036 Scenario: start 50/5; re-pulse start with 9/3 at cycle 5 -> only 10 r 0 is produced, with a single done pulse.
